// File: rtl/block_value_core_if.sv
// Value-transfer bus for block_value_core: `in` flows toward the core and the
// registered copy `out` flows back.
interface block_value_core_if #(
  parameter int DATA_W = 2
);
  logic [DATA_W-1:0] in;
  logic [DATA_W-1:0] out;

  modport master (output in, input out);
  modport slave  (input in, output out);
endinterface

// File: rtl/block_value_core.sv
// Registered value-transfer pipeline: `in` reaches `out` after DEPTH rising
// edges. The reset is asynchronous and active-high, even though the port is named sys_rst_n.
module block_value_core #(
  parameter int DATA_W = 2,
  parameter int DEPTH  = 1
) (
  input  logic                sys_clock,
  input  logic                sys_rst_n,
  block_value_core_if.slave   bus
);

  logic [DATA_W-1:0] stage_q [DEPTH];
  logic [DATA_W-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = bus.in;
    for (int k = 1; k < DEPTH; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  always_ff @(posedge sys_clock or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  // The last stage is a flop, so there is no combinational path from `in` to `out`.
  assign bus.out = stage_q[DEPTH-1];

endmodule

// File: tb/tb_block_value_core.sv
// Bench for block_value_core: DEPTH=1 and DEPTH=3 builds share the clock, the
// reset and the stimulus, and both are compared against a sample-history model.
module tb_block_value_core;

  logic sys_clock;
  logic sys_rst_n;

  block_value_core_if #(.DATA_W(2)) bus1 ();
  block_value_core_if #(.DATA_W(2)) bus3 ();

  block_value_core #(.DATA_W(2), .DEPTH(1)) dut1 (
    .sys_clock (sys_clock),
    .sys_rst_n (sys_rst_n),
    .bus       (bus1.slave)
  );

  block_value_core #(.DATA_W(2), .DEPTH(3)) dut3 (
    .sys_clock (sys_clock),
    .sys_rst_n (sys_rst_n),
    .bus       (bus3.slave)
  );

  initial sys_clock = 1'b0;
  always #10 sys_clock = ~sys_clock;

  int n_vec;
  int n_err;
  // Values accepted since the last reset, oldest first.
  int hist[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] v);
    bus1.in = v;
    bus3.in = v;
  endtask

  function automatic logic [31:0] model_out(input int depth);
    if (hist.size() >= depth) return 32'(hist[hist.size() - depth]);
    return 32'd0;
  endfunction

  // Advance one edge, record the sample, then check both builds.
  task automatic tick(input string tag);
    @(posedge sys_clock);
    if (!sys_rst_n) hist.push_back(int'(bus1.in));
    #1;
    chk({tag, "_d1"}, 32'(bus1.out), model_out(1));
    chk({tag, "_d3"}, 32'(bus3.out), model_out(3));
  endtask

  // A 7 ns pulse placed between edges, checked before any edge arrives.
  task automatic reset_pulse(input string tag);
    #4;
    sys_rst_n = 1'b1;
    hist.delete();
    #1;
    chk({tag, "_d1"}, 32'(bus1.out), 32'd0);
    chk({tag, "_d3"}, 32'(bus3.out), 32'd0);
    #6;
    sys_rst_n = 1'b0;
  endtask

  initial begin
    logic [31:0] seq3_exp [6];
    logic [1:0]  seq3_in  [6];
    n_vec = 0;
    n_err = 0;
    sys_rst_n = 1'b0;
    drive(2'b11);
    // Load both pipelines with nonzero data, so that the reset has something to clear.
    for (int i = 0; i < 4; i++) begin
      @(posedge sys_clock);
      #1;
    end

    // Assert the reset asynchronously and hold it while `in` toggles.
    #4;
    sys_rst_n = 1'b1;
    hist.delete();
    #1;
    chk("rst_async_d1", 32'(bus1.out), 32'd0);
    chk("rst_async_d3", 32'(bus3.out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive((i % 2 == 0) ? 2'b00 : 2'b11);
      tick("rst_hold");
    end
    #9;
    sys_rst_n = 1'b0;

    // Latency with DEPTH=1.
    drive(2'b01);
    tick("lat_a");
    chk("lat_a_direct", 32'(bus1.out), 32'd1);
    drive(2'b10);
    tick("lat_b");
    chk("lat_b_direct", 32'(bus1.out), 32'd2);

    // Directed sequence for the DEPTH=3 build.
    reset_pulse("seq3_rst");
    seq3_in  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0};
    seq3_exp = '{32'd0, 32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
    for (int i = 0; i < 6; i++) begin
      drive(seq3_in[i]);
      tick("seq3");
      chk($sformatf("seq3_direct_%0d", i), 32'(bus3.out), seq3_exp[i]);
    end

    // Hold the input constant.
    drive(2'b11);
    for (int i = 0; i < 10; i++) begin
      tick("hold");
      chk("hold_direct_d1", 32'(bus1.out), 32'd3);
    end

    // Random stream, with a reset pulse in the middle.
    for (int i = 0; i < 100; i++) begin
      drive(2'($urandom % 4));
      tick("rand");
      if (i == 50) reset_pulse("mid_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1);
  end

endmodule
